// File: rtl/execute_md.sv
// execute_md: EXECUTE pipeline stage.
//   Holds the E pipeline register and the rs1/rs2 forwarding muxes, runs a
//   single-cycle ALU, and runs a multi-cycle RV32M multiply/divide unit.
//   Optional feature macro: EXECUTE_MD_DIV_EN. When it is defined, the
//   restoring divider is built. When it is undefined, DIV/DIVU/REM/REMU
//   complete in one cycle with result 0.
//
// Handshake: busy_e is the stage's "not ready". While busy_e is high, the E
// register holds its instruction and valid_e, rd_write_e and mem_write_e are
// forced low, so memory sees a bubble. The cycle busy_e is low with valid_e
// high is the single cycle that the downstream stage accepts the result
// (stall_e can stretch that cycle).
//
// ALU op codes: 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA,
//   8 OR, 9 AND, 10 pass operand B, others 0.
module execute_md #(
    parameter int XLEN       = 32,
    parameter int MUL_CYCLES = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            valid_d,
    input  logic            rd_write_d,
    input  logic [1:0]      rd_write_src_d,
    input  logic            mem_write_d,
    input  logic [3:0]      alu_op_d,
    input  logic            md_d,
    input  logic [2:0]      md_op_d,
    input  logic            src_a_sel_d,
    input  logic            src_b_sel_d,
    input  logic [4:0]      rd_d,
    input  logic [4:0]      rs1_d,
    input  logic [4:0]      rs2_d,
    input  logic [XLEN-1:0] imm_d,
    input  logic [XLEN-1:0] pc_d,
    input  logic [XLEN-1:0] rs1_data_d,
    input  logic [XLEN-1:0] rs2_data_d,
    input  logic [XLEN-1:0] alu_res_m,
    input  logic [XLEN-1:0] rd_data_w,
    input  logic            stall_e,
    input  logic            flush_e,
    input  logic [1:0]      fwd_rs1_e,
    input  logic [1:0]      fwd_rs2_e,
    output logic            valid_e,
    output logic            rd_write_e,
    output logic [1:0]      rd_write_src_e,
    output logic            mem_write_e,
    output logic [4:0]      rd_e,
    output logic [4:0]      rs1_e,
    output logic [4:0]      rs2_e,
    output logic [XLEN-1:0] pc_e,
    output logic [XLEN-1:0] res_e,
    output logic [XLEN-1:0] mem_data_e,
    output logic            busy_e,
    output logic [1:0]      md_state_e
);

    localparam int SHW = $clog2(XLEN);

`ifdef EXECUTE_MD_DIV_EN
    localparam logic DIV_EN = 1'b1;
`else
    localparam logic DIV_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } md_state_t;

    md_state_t state, state_n;

    // E pipeline register contents
    logic            valid_q, rd_write_q, mem_write_q, md_q;
    logic            src_a_sel_q, src_b_sel_q;
    logic [1:0]      rd_write_src_q;
    logic [3:0]      alu_op_q;
    logic [2:0]      md_op_q;
    logic [4:0]      rd_q, rs1_q, rs2_q;
    logic [XLEN-1:0] imm_q, pc_q, rs1_data_q, rs2_data_q;

    // Datapath signals
    logic [XLEN-1:0] fwd_a, fwd_b, alu_a, alu_b, alu_res;
    logic [SHW-1:0]  shamt;

    // Mul/div operands latched at start, so forward sources may change while busy
    logic [XLEN-1:0]   op_a, op_b;
    logic [2:0]        op_code;
    logic [15:0]       cnt;
    logic              a_sgn, b_sgn;
    logic [2*XLEN-1:0] mul_a_x, mul_b_x, mul_full;
    logic [XLEN-1:0]   mul_res, div_res, md_res;

    // E register: flush clears it and beats stall; stall or busy holds it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q        <= 1'b0;
            rd_write_q     <= 1'b0;
            rd_write_src_q <= 2'b00;
            mem_write_q    <= 1'b0;
            alu_op_q       <= 4'd0;
            md_q           <= 1'b0;
            md_op_q        <= 3'd0;
            src_a_sel_q    <= 1'b0;
            src_b_sel_q    <= 1'b0;
            rd_q           <= 5'd0;
            rs1_q          <= 5'd0;
            rs2_q          <= 5'd0;
            imm_q          <= '0;
            pc_q           <= '0;
            rs1_data_q     <= '0;
            rs2_data_q     <= '0;
        end else if (flush_e) begin
            valid_q        <= 1'b0;
            rd_write_q     <= 1'b0;
            rd_write_src_q <= 2'b00;
            mem_write_q    <= 1'b0;
            alu_op_q       <= 4'd0;
            md_q           <= 1'b0;
            md_op_q        <= 3'd0;
            src_a_sel_q    <= 1'b0;
            src_b_sel_q    <= 1'b0;
            rd_q           <= 5'd0;
            rs1_q          <= 5'd0;
            rs2_q          <= 5'd0;
            imm_q          <= '0;
            pc_q           <= '0;
            rs1_data_q     <= '0;
            rs2_data_q     <= '0;
        end else if (!stall_e && !busy_e) begin
            valid_q        <= valid_d;
            rd_write_q     <= rd_write_d;
            rd_write_src_q <= rd_write_src_d;
            mem_write_q    <= mem_write_d;
            alu_op_q       <= alu_op_d;
            md_q           <= md_d;
            md_op_q        <= md_op_d;
            src_a_sel_q    <= src_a_sel_d;
            src_b_sel_q    <= src_b_sel_d;
            rd_q           <= rd_d;
            rs1_q          <= rs1_d;
            rs2_q          <= rs2_d;
            imm_q          <= imm_d;
            pc_q           <= pc_d;
            rs1_data_q     <= rs1_data_d;
            rs2_data_q     <= rs2_data_d;
        end
    end

    // Forwarding muxes and ALU operand selection
    always_comb begin
        case (fwd_rs1_e)
            2'b01:   fwd_a = rd_data_w;
            2'b10:   fwd_a = alu_res_m;
            default: fwd_a = rs1_data_q;
        endcase
        case (fwd_rs2_e)
            2'b01:   fwd_b = rd_data_w;
            2'b10:   fwd_b = alu_res_m;
            default: fwd_b = rs2_data_q;
        endcase
        alu_a = src_a_sel_q ? pc_q : fwd_a;
        alu_b = src_b_sel_q ? imm_q : fwd_b;
        shamt = alu_b[SHW-1:0];
    end

    // Single-cycle ALU
    always_comb begin
        alu_res = '0;
        case (alu_op_q)
            4'd0:    alu_res = alu_a + alu_b;
            4'd1:    alu_res = alu_a - alu_b;
            4'd2:    alu_res = alu_a << shamt;
            4'd3:    alu_res = {{(XLEN-1){1'b0}}, ($signed(alu_a) < $signed(alu_b))};
            4'd4:    alu_res = {{(XLEN-1){1'b0}}, (alu_a < alu_b)};
            4'd5:    alu_res = alu_a ^ alu_b;
            4'd6:    alu_res = alu_a >> shamt;
            4'd7:    alu_res = XLEN'($signed(alu_a) >>> shamt);
            4'd8:    alu_res = alu_a | alu_b;
            4'd9:    alu_res = alu_a & alu_b;
            4'd10:   alu_res = alu_b;
            default: alu_res = '0;
        endcase
    end

    // Mul/div FSM next state and busy; a start raises busy in the same cycle
    always_comb begin
        state_n = state;
        busy_e  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (valid_q && md_q && (!md_op_q[2] || DIV_EN)) begin
                    busy_e = 1'b1;
                    if (flush_e)
                        state_n = ST_IDLE;
                    else if (md_op_q[2])
                        state_n = ST_DIV;
                    else if (MUL_CYCLES > 1)
                        state_n = ST_MUL;
                    else
                        state_n = ST_DONE;
                end
            end
            ST_MUL: begin
                busy_e = 1'b1;
                if (flush_e)
                    state_n = ST_IDLE;
                else if (cnt == 16'(MUL_CYCLES - 2))
                    state_n = ST_DONE;
            end
            ST_DIV: begin
                busy_e = 1'b1;
                if (flush_e)
                    state_n = ST_IDLE;
                else if (cnt == 16'(XLEN - 1))
                    state_n = ST_DONE;
            end
            ST_DONE: begin
                if (flush_e || !stall_e)
                    state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // FSM state, cycle counter, and operand latch taken while idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            cnt     <= 16'd0;
            op_a    <= '0;
            op_b    <= '0;
            op_code <= 3'd0;
        end else begin
            state <= state_n;
            if (state == ST_IDLE) begin
                cnt     <= 16'd0;
                op_a    <= fwd_a;
                op_b    <= fwd_b;
                op_code <= md_op_q;
            end else if (state == ST_MUL || state == ST_DIV) begin
                cnt <= cnt + 16'd1;
            end
        end
    end

    // Multiplier: sign-extend to 2*XLEN, so one unsigned product covers every signedness
    always_comb begin
        a_sgn    = (op_code[1:0] == 2'b01) || (op_code[1:0] == 2'b10);
        b_sgn    = (op_code[1:0] == 2'b01);
        mul_a_x  = {{XLEN{a_sgn & op_a[XLEN-1]}}, op_a};
        mul_b_x  = {{XLEN{b_sgn & op_b[XLEN-1]}}, op_b};
        mul_full = mul_a_x * mul_b_x;
        mul_res  = (op_code[1:0] == 2'b00) ? mul_full[XLEN-1:0] : mul_full[2*XLEN-1:XLEN];
    end

`ifdef EXECUTE_MD_DIV_EN
    logic [XLEN-1:0] div_q, div_r, div_d, abs_a, abs_b, q_fix, r_fix;
    logic [XLEN:0]   div_shift, div_diff;
    logic            div_sgn_d, q_neg, r_neg, div_zero;

    // Divider magnitudes, one restoring step, and the final sign fix
    always_comb begin
        div_sgn_d = ~md_op_q[0];
        abs_a     = (div_sgn_d && fwd_a[XLEN-1]) ? -fwd_a : fwd_a;
        abs_b     = (div_sgn_d && fwd_b[XLEN-1]) ? -fwd_b : fwd_b;
        div_shift = {div_r, div_q[XLEN-1]};
        div_diff  = div_shift - {1'b0, div_d};
        q_neg     = ~op_code[0] & (op_a[XLEN-1] ^ op_b[XLEN-1]);
        r_neg     = ~op_code[0] & op_a[XLEN-1];
        div_zero  = (op_b == '0);
        q_fix     = q_neg ? -div_q : div_q;
        r_fix     = r_neg ? -div_r : div_r;
        if (op_code[1])
            div_res = div_zero ? op_a : r_fix;
        else
            div_res = div_zero ? '1 : q_fix;
    end

    // Restoring divide: quotient bits shift in as dividend bits shift out
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= '0;
            div_r <= '0;
            div_d <= '0;
        end else if (state == ST_IDLE) begin
            div_q <= abs_a;
            div_r <= '0;
            div_d <= abs_b;
        end else if (state == ST_DIV) begin
            if (!div_diff[XLEN]) begin
                div_r <= div_diff[XLEN-1:0];
                div_q <= {div_q[XLEN-2:0], 1'b1};
            end else begin
                div_r <= div_shift[XLEN-1:0];
                div_q <= {div_q[XLEN-2:0], 1'b0};
            end
        end
    end
`else
    assign div_res = '0;
`endif

    // Output selection: bubbles read as zero, md results only once DONE
    always_comb begin
        md_res     = op_code[2] ? div_res : mul_res;
        res_e      = '0;
        mem_data_e = '0;
        if (valid_q) begin
            mem_data_e = fwd_b;
            if (!md_q)
                res_e = alu_res;
            else if (state == ST_DONE)
                res_e = md_res;
        end
    end

    assign valid_e        = valid_q & ~busy_e;
    assign rd_write_e     = rd_write_q & valid_e;
    assign mem_write_e    = mem_write_q & valid_e;
    assign rd_write_src_e = rd_write_src_q;
    assign rd_e           = rd_q;
    assign rs1_e          = rs1_q;
    assign rs2_e          = rs2_q;
    assign pc_e           = pc_q;
    assign md_state_e     = state;

endmodule

// File: tb/tb_execute_md.sv
// tb_execute_md: directed bench for execute_md with an expected-result queue.
module tb_execute_md;

    localparam int XLEN       = 32;
    localparam int MUL_CYCLES = 3;
`ifdef EXECUTE_MD_DIV_EN
    localparam logic DIV_ON = 1'b1;
`else
    localparam logic DIV_ON = 1'b0;
`endif
    localparam int DIV_BUSY = DIV_ON ? XLEN + 1 : 0;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_SRA = 4'd7;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            valid_d, rd_write_d, mem_write_d, md_d, src_a_sel_d, src_b_sel_d;
    logic [1:0]      rd_write_src_d;
    logic [3:0]      alu_op_d;
    logic [2:0]      md_op_d;
    logic [4:0]      rd_d, rs1_d, rs2_d;
    logic [XLEN-1:0] imm_d, pc_d, rs1_data_d, rs2_data_d, alu_res_m, rd_data_w;
    logic            stall_e, flush_e;
    logic [1:0]      fwd_rs1_e, fwd_rs2_e;
    logic            valid_e, rd_write_e, mem_write_e, busy_e;
    logic [1:0]      rd_write_src_e, md_state_e;
    logic [4:0]      rd_e, rs1_e, rs2_e;
    logic [XLEN-1:0] pc_e, res_e, mem_data_e;

    int total = 0;
    int bad   = 0;
    logic [XLEN-1:0] exp_q[$];

    execute_md #(.XLEN(XLEN), .MUL_CYCLES(MUL_CYCLES)) dut (
        .clk(clk), .rst_n(rst_n), .valid_d(valid_d), .rd_write_d(rd_write_d),
        .rd_write_src_d(rd_write_src_d), .mem_write_d(mem_write_d), .alu_op_d(alu_op_d),
        .md_d(md_d), .md_op_d(md_op_d), .src_a_sel_d(src_a_sel_d), .src_b_sel_d(src_b_sel_d),
        .rd_d(rd_d), .rs1_d(rs1_d), .rs2_d(rs2_d), .imm_d(imm_d), .pc_d(pc_d),
        .rs1_data_d(rs1_data_d), .rs2_data_d(rs2_data_d), .alu_res_m(alu_res_m),
        .rd_data_w(rd_data_w), .stall_e(stall_e), .flush_e(flush_e),
        .fwd_rs1_e(fwd_rs1_e), .fwd_rs2_e(fwd_rs2_e), .valid_e(valid_e),
        .rd_write_e(rd_write_e), .rd_write_src_e(rd_write_src_e), .mem_write_e(mem_write_e),
        .rd_e(rd_e), .rs1_e(rs1_e), .rs2_e(rs2_e), .pc_e(pc_e), .res_e(res_e),
        .mem_data_e(mem_data_e), .busy_e(busy_e), .md_state_e(md_state_e)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Driver: D-stage bubble
    task automatic idle_inputs();
        valid_d        = 1'b0;
        rd_write_d     = 1'b0;
        rd_write_src_d = 2'b00;
        mem_write_d    = 1'b0;
        alu_op_d       = 4'd0;
        md_d           = 1'b0;
        md_op_d        = 3'd0;
        src_a_sel_d    = 1'b0;
        src_b_sel_d    = 1'b0;
        rd_d           = 5'd0;
        rs1_d          = 5'd0;
        rs2_d          = 5'd0;
        imm_d          = '0;
        pc_d           = '0;
        rs1_data_d     = '0;
        rs2_data_d     = '0;
    endtask

    // Driver: present one instruction, clock it into E, then drive a bubble
    task automatic issue(input logic md, input logic [2:0] mdop, input logic [3:0] aluop,
                         input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                         input logic bsel, input logic [XLEN-1:0] imm, input logic [XLEN-1:0] pc);
        valid_d        = 1'b1;
        rd_write_d     = 1'b1;
        rd_write_src_d = 2'b01;
        mem_write_d    = 1'b0;
        alu_op_d       = aluop;
        md_d           = md;
        md_op_d        = mdop;
        src_a_sel_d    = 1'b0;
        src_b_sel_d    = bsel;
        rd_d           = 5'd10;
        rs1_d          = 5'd11;
        rs2_d          = 5'd12;
        imm_d          = imm;
        pc_d           = pc;
        rs1_data_d     = a;
        rs2_data_d     = b;
        @(posedge clk); #1;
        idle_inputs();
    endtask

    // Scoreboard: count busy cycles (bounded), then pop and compare the result
    task automatic finish_op(input string tag, input int exp_busy);
        int n;
        logic [XLEN-1:0] exp;
        n = 0;
        while (busy_e === 1'b1 && n < 100) begin
            n++;
            @(posedge clk); #1;
        end
        check({tag, "_busy"}, n, exp_busy);
        check1({tag, "_valid"}, valid_e, 1'b1);
        exp = exp_q.pop_front();
        check({tag, "_res"}, res_e, exp);
    endtask

    task automatic md_step(input string tag, input logic [2:0] mdop,
                           input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                           input logic [XLEN-1:0] exp, input int exp_busy);
        exp_q.push_back(exp);
        issue(1'b1, mdop, OP_ADD, a, b, 1'b0, '0, 32'h400);
        finish_op(tag, exp_busy);
    endtask

    initial begin
        rst_n     = 1'b0;
        stall_e   = 1'b0;
        flush_e   = 1'b0;
        fwd_rs1_e = 2'b00;
        fwd_rs2_e = 2'b00;
        alu_res_m = '0;
        rd_data_w = '0;
        idle_inputs();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check1("rst_valid", valid_e, 1'b0);
        check1("rst_busy", busy_e, 1'b0);
        check("rst_res", res_e, '0);
        check("rst_pc", pc_e, '0);
        check("rst_state", {30'b0, md_state_e}, '0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // ADD with immediate
        exp_q.push_back(32'd12);
        issue(1'b0, 3'd0, OP_ADD, 32'd5, 32'd99, 1'b1, 32'd7, 32'h100);
        check("add_pc", pc_e, 32'h100);
        check("add_rd", {27'b0, rd_e}, 32'd10);
        check1("add_rdw", rd_write_e, 1'b1);
        finish_op("add", 0);

        // Forwarding from memory stage into rs1
        fwd_rs1_e = 2'b10;
        alu_res_m = 32'h100;
        exp_q.push_back(32'h101);
        issue(1'b0, 3'd0, OP_ADD, 32'hdead, 32'd1, 1'b0, '0, 32'h104);
        finish_op("fwd_a", 0);
        fwd_rs1_e = 2'b00;

        // Forwarding from writeback into rs2 / store data
        fwd_rs2_e = 2'b01;
        rd_data_w = 32'hAA;
        exp_q.push_back(32'h14);
        issue(1'b0, 3'd0, OP_ADD, 32'h10, 32'h55, 1'b1, 32'd4, 32'h108);
        check("fwd_b_mem", mem_data_e, 32'hAA);
        finish_op("fwd_b", 0);
        fwd_rs2_e = 2'b00;

        exp_q.push_back(32'd5);
        issue(1'b0, 3'd0, OP_SUB, 32'd12, 32'd7, 1'b0, '0, 32'h10c);
        finish_op("sub", 0);
        exp_q.push_back(32'hF8000000);
        issue(1'b0, 3'd0, OP_SRA, 32'h80000000, 32'd0, 1'b1, 32'd4, 32'h110);
        finish_op("sra", 0);

        // Multiplies
        md_step("mulhu", 3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, MUL_CYCLES);
        md_step("mul", 3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, MUL_CYCLES);

        // Result holds in DONE under stall
        stall_e = 1'b1;
        @(posedge clk); #1;
        check1("stall_valid", valid_e, 1'b1);
        check("stall_res", res_e, 32'h00000001);
        check("stall_state", {30'b0, md_state_e}, 32'd3);
        stall_e = 1'b0;

        md_step("mulh", 3'd1, 32'h80000000, 32'h80000000, 32'h40000000, MUL_CYCLES);
        md_step("mulhsu", 3'd2, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, MUL_CYCLES);
        md_step("mulhu2", 3'd3, 32'hFFFFFFFF, 32'd2, 32'h00000001, MUL_CYCLES);

        // Operands latched at start: forward source changes mid-op are ignored
        fwd_rs1_e = 2'b10;
        alu_res_m = 32'd6;
        exp_q.push_back(32'd42);
        issue(1'b1, 3'd0, OP_ADD, 32'd0, 32'd7, 1'b0, '0, 32'h120);
        @(posedge clk); #1;
        alu_res_m = 32'd100;
        finish_op("mul_latch", MUL_CYCLES - 1);
        fwd_rs1_e = 2'b00;
        alu_res_m = '0;

        // Divides and corner cases
        md_step("div_ovf", 3'd4, 32'h80000000, 32'hFFFFFFFF, DIV_ON ? 32'h80000000 : '0, DIV_BUSY);
        md_step("divu_z", 3'd5, 32'd7, 32'd0, DIV_ON ? 32'hFFFFFFFF : '0, DIV_BUSY);
        md_step("rem_z", 3'd6, 32'd7, 32'd0, DIV_ON ? 32'd7 : '0, DIV_BUSY);
        md_step("rem_neg", 3'd6, 32'hFFFFFFF9, 32'd2, DIV_ON ? 32'hFFFFFFFF : '0, DIV_BUSY);
        md_step("div_neg", 3'd4, 32'hFFFFFFF9, 32'd2, DIV_ON ? 32'hFFFFFFFD : '0, DIV_BUSY);
        md_step("remu", 3'd7, 32'd100, 32'd7, DIV_ON ? 32'd2 : '0, DIV_BUSY);
        md_step("rem_ovf", 3'd6, 32'h80000000, 32'hFFFFFFFF, '0, DIV_BUSY);
        md_step("div_negz", 3'd4, 32'hFFFFFFF8, 32'd0, DIV_ON ? 32'hFFFFFFFF : '0, DIV_BUSY);

        // Flush in the 10th busy cycle of a divide
        issue(1'b1, 3'd4, OP_ADD, 32'd100, 32'd3, 1'b0, '0, 32'h130);
        for (int i = 0; i < 9; i++) begin
            @(posedge clk); #1;
        end
        check1("flush_pre_busy", busy_e, DIV_ON);
        check1("flush_pre_rdw", rd_write_e, 1'b0);
        flush_e = 1'b1;
        @(posedge clk); #1;
        flush_e = 1'b0;
        check1("flush_busy", busy_e, 1'b0);
        check1("flush_valid", valid_e, 1'b0);
        check("flush_state", {30'b0, md_state_e}, '0);
        exp_q.push_back(32'd2);
        issue(1'b0, 3'd0, OP_ADD, 32'd1, 32'd1, 1'b0, '0, 32'h134);
        finish_op("after_flush", 0);

        // Reset in the 2nd multiply cycle
        issue(1'b1, 3'd0, OP_ADD, 32'd9, 32'd9, 1'b0, '0, 32'h200);
        @(posedge clk); #1;
        check1("rst_mid_pre_busy", busy_e, 1'b1);
        rst_n = 1'b0;
        #1;
        check1("rst_mid_busy", busy_e, 1'b0);
        check1("rst_mid_valid", valid_e, 1'b0);
        check("rst_mid_res", res_e, '0);
        check("rst_mid_pc", pc_e, '0);
        check("rst_mid_state", {30'b0, md_state_e}, '0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        md_step("mul_after_rst", 3'd0, 32'd6, 32'd7, 32'd42, MUL_CYCLES);

        check("sb_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
